// File: rtl/timebase_pkg.sv
// Shared definitions for the alarm clock timebase.
// Mode encodings and the counter width helper.
package timebase_pkg;

    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_FAST   = 2'd1;
    localparam logic [1:0] MODE_STEP   = 2'd2;
    localparam logic [1:0] MODE_HOLD   = 2'd3;

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD counter with synchronous clear and count enable.
// Ports: clock, reset (async, high), clr, en -> count, wrap.
module mod_counter #(
    parameter int MOD = 4,
    parameter int W   = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign wrap  = en && (count_q == W'(MOD - 1));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = wrap ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alarm_timebase.sv
// Alarm clock timebase: second/minute/hour tick pulses and blink.
// Ports: clock, reset, reset_count, mode[1:0], step ->
//   one_second, one_minute, one_hour, blink, sec_count, min_count.
module alarm_timebase
    import timebase_pkg::*;
#(
    parameter int TICKS_PER_SEC = 256,
    parameter int SECS_PER_MIN  = 60,
    parameter int MINS_PER_HOUR = 60
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             reset_count,
    input  logic [1:0]                       mode,
    input  logic                             step,
    output logic                             one_second,
    output logic                             one_minute,
    output logic                             one_hour,
    output logic                             blink,
    output logic [cnt_w(SECS_PER_MIN)-1:0]   sec_count,
    output logic [cnt_w(MINS_PER_HOUR)-1:0]  min_count
);

    localparam int PRE_W = cnt_w(TICKS_PER_SEC);
    localparam int SEC_W = cnt_w(SECS_PER_MIN);
    localparam int MIN_W = cnt_w(MINS_PER_HOUR);

    logic             hold;
    logic             sec_tick;
    logic             raw_min;
    logic             min_tick;
    logic             min_wrap;
    logic             step_rise;
    logic [PRE_W-1:0] pre_count;

    logic step_q, step_d;
    logic one_second_q, one_second_d;
    logic one_minute_q, one_minute_d;
    logic one_hour_q, one_hour_d;
    logic blink_q, blink_d;

    assign hold      = (mode == MODE_HOLD);
    assign step_rise = step & ~step_q;

    mod_counter #(.MOD(TICKS_PER_SEC), .W(PRE_W)) u_pre (
        .clock (clock),
        .reset (reset),
        .clr   (reset_count),
        .en    (~hold),
        .count (pre_count),
        .wrap  (sec_tick)
    );

    mod_counter #(.MOD(SECS_PER_MIN), .W(SEC_W)) u_sec (
        .clock (clock),
        .reset (reset),
        .clr   (reset_count),
        .en    (sec_tick),
        .count (sec_count),
        .wrap  (raw_min)
    );

    mod_counter #(.MOD(MINS_PER_HOUR), .W(MIN_W)) u_min (
        .clock (clock),
        .reset (reset),
        .clr   (reset_count),
        .en    (min_tick),
        .count (min_count),
        .wrap  (min_wrap)
    );

    // Minute source; in STEP the natural minute rollover is discarded.
    always_comb begin
        min_tick = 1'b0;
        unique case (mode)
            MODE_NORMAL: min_tick = raw_min;
            MODE_FAST:   min_tick = sec_tick;
            MODE_STEP:   min_tick = step_rise;
            MODE_HOLD:   min_tick = 1'b0;
            default:     min_tick = 1'b0;
        endcase
    end

    always_comb begin
        // Edge detector keeps tracking step even while counters clear.
        step_d       = step;
        one_second_d = sec_tick;
        one_minute_d = min_tick;
        one_hour_d   = min_wrap;
        blink_d      = hold ? blink_q
                            : (pre_count >= PRE_W'(TICKS_PER_SEC / 2));
        if (reset_count) begin
            one_second_d = 1'b0;
            one_minute_d = 1'b0;
            one_hour_d   = 1'b0;
            blink_d      = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            step_q       <= 1'b0;
            one_second_q <= 1'b0;
            one_minute_q <= 1'b0;
            one_hour_q   <= 1'b0;
            blink_q      <= 1'b0;
        end else begin
            step_q       <= step_d;
            one_second_q <= one_second_d;
            one_minute_q <= one_minute_d;
            one_hour_q   <= one_hour_d;
            blink_q      <= blink_d;
        end
    end

    assign one_second = one_second_q;
    assign one_minute = one_minute_q;
    assign one_hour   = one_hour_q;
    assign blink      = blink_q;

endmodule

// File: tb/tb_alarm_timebase.sv
// Directed self-checking bench for alarm_timebase.
// Small parameters: 4 ticks/s, 3 s/min, 2 min/h.
module tb_alarm_timebase;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       reset_count = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       step = 1'b0;
    logic       one_second;
    logic       one_minute;
    logic       one_hour;
    logic       blink;
    logic [1:0] sec_count;
    logic [0:0] min_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    alarm_timebase #(
        .TICKS_PER_SEC (4),
        .SECS_PER_MIN  (3),
        .MINS_PER_HOUR (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .reset_count (reset_count),
        .mode        (mode),
        .step        (step),
        .one_second  (one_second),
        .one_minute  (one_minute),
        .one_hour    (one_hour),
        .blink       (blink),
        .sec_count   (sec_count),
        .min_count   (min_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample on the falling edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic do_reset(input logic [1:0] m);
        @(negedge clock);
        reset = 1'b1;
        mode = m;
        step = 1'b0;
        reset_count = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        cyc = 0;
    endtask

    // NORMAL from reset: seconds every 4, minutes every 12, hour at 24.
    task automatic run_normal(input string tag, input int n);
        for (int c = 1; c <= n; c++) begin
            tick();
            chk($sformatf("%s_sec c%0d", tag, c), 32'(one_second),
                32'(c % 4 == 0));
            chk($sformatf("%s_min c%0d", tag, c), 32'(one_minute),
                32'(c % 12 == 0));
            chk($sformatf("%s_hour c%0d", tag, c), 32'(one_hour),
                32'(c == 24));
            chk($sformatf("%s_blink c%0d", tag, c), 32'(blink),
                32'(((c - 1) % 4) >= 2));
        end
    endtask

    initial begin
        // Reset state
        @(negedge clock);
        chk("rst_sec", 32'(one_second), 0);
        chk("rst_min", 32'(one_minute), 0);
        chk("rst_hour", 32'(one_hour), 0);
        chk("rst_blink", 32'(blink), 0);
        chk("rst_sec_count", 32'(sec_count), 0);
        chk("rst_min_count", 32'(min_count), 0);
        reset = 1'b0;
        cyc = 0;

        // 1. NORMAL
        run_normal("s1", 25);

        // 2. FAST
        do_reset(2'd1);
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk($sformatf("s2_sec c%0d", c), 32'(one_second),
                32'(c % 4 == 0));
            chk($sformatf("s2_min c%0d", c), 32'(one_minute),
                32'(c % 4 == 0));
            chk($sformatf("s2_hour c%0d", c), 32'(one_hour),
                32'(c % 8 == 0));
            chk($sformatf("s2_mcnt c%0d", c), 32'(min_count),
                32'((c / 4) % 2));
        end

        // 3. STEP: step high during cycles 5-7 and 20-22
        do_reset(2'd2);
        for (int c = 1; c <= 24; c++) begin
            tick();
            chk($sformatf("s3_sec c%0d", c), 32'(one_second),
                32'(c % 4 == 0));
            chk($sformatf("s3_min c%0d", c), 32'(one_minute),
                32'(c == 6 || c == 21));
            chk($sformatf("s3_hour c%0d", c), 32'(one_hour),
                32'(c == 21));
            chk($sformatf("s3_mcnt c%0d", c), 32'(min_count),
                32'(c >= 6 && c < 21));
            step = ((c >= 5 && c <= 7) || (c >= 20 && c <= 22));
        end

        // Entering STEP with step already high gives no tick
        do_reset(2'd0);
        step = 1'b1;
        tick();
        mode = 2'd2;
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk($sformatf("s3b_min c%0d", c), 32'(one_minute), 0);
        end
        step = 1'b0;

        // 4. HOLD for cycles 7..16
        do_reset(2'd0);
        repeat (6) tick();
        chk("s4_pre_scnt", 32'(sec_count), 1);
        mode = 2'd3;
        for (int c = 7; c <= 16; c++) begin
            tick();
            chk($sformatf("s4_sec c%0d", c), 32'(one_second), 0);
            chk($sformatf("s4_min c%0d", c), 32'(one_minute), 0);
            chk($sformatf("s4_scnt c%0d", c), 32'(sec_count), 1);
            chk($sformatf("s4_mcnt c%0d", c), 32'(min_count), 0);
            chk($sformatf("s4_blink c%0d", c), 32'(blink), 0);
        end
        mode = 2'd0;
        tick();
        chk("s4_sec c17", 32'(one_second), 0);
        chk("s4_blink c17", 32'(blink), 1);
        tick();
        chk("s4_sec c18", 32'(one_second), 1);
        chk("s4_scnt c18", 32'(sec_count), 2);

        // 5. reset_count during cycle 11
        do_reset(2'd0);
        repeat (11) tick();
        chk("s5_scnt c11", 32'(sec_count), 2);
        reset_count = 1'b1;
        tick();
        reset_count = 1'b0;
        chk("s5_sec c12", 32'(one_second), 0);
        chk("s5_min c12", 32'(one_minute), 0);
        chk("s5_scnt c12", 32'(sec_count), 0);
        chk("s5_blink c12", 32'(blink), 0);
        for (int c = 13; c <= 16; c++) begin
            tick();
            chk($sformatf("s5_sec c%0d", c), 32'(one_second),
                32'(c == 16));
        end
        chk("s5_scnt c16", 32'(sec_count), 1);

        // 6. Asynchronous reset with pre=2, sec=1
        do_reset(2'd0);
        repeat (6) tick();
        chk("s6_scnt_before", 32'(sec_count), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("s6_scnt_async", 32'(sec_count), 0);
        chk("s6_sec_async", 32'(one_second), 0);
        chk("s6_blink_async", 32'(blink), 0);
        @(negedge clock);
        reset = 1'b0;
        cyc = 0;
        run_normal("s6", 13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alarm_timebase.md
Name: alarm_timebase

Overview:
Parametrised timebase for the alarm clock. It divides the system clock into one-cycle second, minute and hour tick pulses, plus a 50%-duty blink signal for display flashing. It supports normal, fast, single-step and hold modes, and exposes the live second and minute counts. It sits between the clock input and the time/alarm counters, and replaces the fixed-divider second/minute generator.

Parameters:
TICKS_PER_SEC, 256, clock cycles per second tick; must be >= 2 and even.
SECS_PER_MIN, 60, second ticks per minute tick; must be >= 2.
MINS_PER_HOUR, 60, minute ticks per hour tick; must be >= 2.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
reset_count  input  1  synchronous clear of all counters and pulses.
mode  input  2  0 NORMAL, 1 FAST, 2 STEP, 3 HOLD.
step  input  1  synchronous level; each rising edge gives one minute tick in STEP mode.
one_second  output  1  one-cycle pulse per second.
one_minute  output  1  one-cycle pulse per minute, source selected by mode.
one_hour  output  1  one-cycle pulse per MINS_PER_HOUR minute ticks.
blink  output  1  low for the first half of each second, high for the second half.
sec_count  output  clog2(SECS_PER_MIN)  seconds elapsed in the current minute.
min_count  output  clog2(MINS_PER_HOUR)  minute ticks elapsed in the current hour.

Behaviour:
- Reset values: all outputs 0; pre, sec, min counters 0; step edge register 0.
- Priority on every edge: reset > reset_count > mode logic.
- reset_count:
  - Same effects as reset, applied at the next edge.
  - The step edge register still samples step.
- Prescaler pre:
  - Counts 0..TICKS_PER_SEC-1 every cycle unless mode==HOLD, in which case it is frozen.
  - Wrap condition: pre==TICKS_PER_SEC-1 and not HOLD.
  - On wrap: pre<=0 and sec_tick is internally true.
- one_second:
  - Registered, one_second<=sec_tick.
  - It is high for exactly one cycle every TICKS_PER_SEC cycles.
  - First assertion is in the cycle after the TICKS_PER_SEC-th rising edge following reset release.
- Second counter sec:
  - Increments on sec_tick.
  - On sec_tick with sec==SECS_PER_MIN-1: sec<=0 and raw_min is true.
- Minute source, evaluated in the same cycle as sec_tick:
  - NORMAL: raw_min.
  - FAST: sec_tick.
  - STEP: step & ~step_q (rising edge).
  - HOLD: 0.
- one_minute:
  - Registered, one_minute<=min_tick.
  - It coincides with one_second in NORMAL and FAST.
  - In STEP it asserts one cycle after the step rising edge.
  - step is assumed already synchronous and debounced.
- Minute counter min:
  - Increments on min_tick.
  - On wrap from MINS_PER_HOUR-1: min<=0 and one_hour<=1 for one cycle.
  - one_hour asserts in the same cycle as that one_minute.
- In STEP mode the prescaler and sec still run and one_second still pulses; raw_min is discarded.
- HOLD: no pulses, all counters frozen. blink holds its value.
- blink: registered, high when pre >= TICKS_PER_SEC/2 (value before increment).
- Mode change:
  - Takes effect for the next min_tick evaluation.
  - Counters are not cleared.
  - Entering STEP with step already high produces no tick.
- A simultaneous step edge and raw_min in STEP gives exactly one tick (from step).
- sec_count and min_count are the register values directly.

Decomposition:
- Shared package timebase_pkg: mode constants MODE_NORMAL/FAST/STEP/HOLD (2-bit) and the width helper for counter widths.
- Sub-module mod_counter (params MOD, W):
  - Inputs: clock, reset, clr, en.
  - Outputs: count, wrap (combinational, en && count==MOD-1).
  - Instantiated three times: prescaler, seconds, minutes.

Test Plan:
Use TICKS_PER_SEC=4, SECS_PER_MIN=3, MINS_PER_HOUR=2 for all scenarios.
1. NORMAL from reset -> one_second at cycles 4, 8, 12; one_minute at 12, 24; one_hour at 24; blink pattern 0,0,1,1 per second.
2. FAST -> one_minute equals one_second every 4 cycles; one_hour every 8 cycles; min_count toggles 0,1,0.
3. STEP, step pulses of 3 cycles high at cycles 5 and 20 -> exactly two one_minute pulses, at cycles 6 and 21; one_hour at 21; no minute tick when sec wraps at 12.
4. HOLD entered at cycle 6 for 10 cycles -> no pulses; pre, sec, min and blink frozen; on return to NORMAL the next one_second arrives 2 cycles later.
5. reset_count asserted at cycle 11, one cycle -> all counts 0 next cycle, no one_second at 12; next one_second 4 cycles after release.
6. Asynchronous reset mid-second (pre=2, sec=1) -> outputs 0 immediately without a clock edge; recovery timing identical to scenario 1.
